// File: rtl/present_round_ctrl_pkg.sv
// present_ctrl_pkg: shared definitions for the PRESENT round sequencer.
//   - ctrl_state_e   : sequencer states (IDLE, LOAD, ROUND, DONE)
//   - DEF_NUM_ROUNDS : default number of full rounds
//   - DEF_SBOX_LAT   : default cycles per round (shared S-box depth)
//   - rc_w()         : round counter width for a given round count
//   - ph_w()         : phase counter width for a given S-box latency
package present_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  localparam int DEF_NUM_ROUNDS = 31;
  localparam int DEF_SBOX_LAT   = 4;

  // Counter must hold 0 (idle) as well as 1..num_rounds.
  function automatic int rc_w(input int num_rounds);
    return $clog2(num_rounds + 1);
  endfunction

  // A single-stage S-box still gets a 1-bit phase that stays at 0.
  function automatic int ph_w(input int sbox_lat);
    return (sbox_lat > 1) ? $clog2(sbox_lat) : 1;
  endfunction

endpackage

// File: rtl/present_round_ctrl_if.sv
// present_round_ctrl_if: control bundle between the test wrapper / datapath
// and the PRESENT round sequencer.
//   start      wrapper -> ctrl  begin encryption (sampled in IDLE)
//   abort      wrapper -> ctrl  cancel encryption (PRESENT_CTRL_ABORT_EN only)
//   ready      ctrl -> wrapper  sequencer idle
//   sel_load   ctrl -> datapath 1 = capture plaintext/key, 0 = round feedback
//   key_upd    ctrl -> datapath key schedule advances this edge
//   round_cnt  ctrl -> datapath current round, 0 outside an encryption
//   phase      ctrl -> datapath S-box pipeline phase
//   last_round ctrl -> datapath final round in progress
//   done       ctrl -> wrapper  ciphertext valid this cycle
// Modports: master = wrapper side, slave = sequencer side.
// Optional feature macro: PRESENT_CTRL_ABORT_EN.
interface present_round_ctrl_if import present_ctrl_pkg::*; #(
  parameter int RC_W = rc_w(DEF_NUM_ROUNDS),
  parameter int PH_W = ph_w(DEF_SBOX_LAT)
);

  logic            start;
`ifdef PRESENT_CTRL_ABORT_EN
  logic            abort;
`endif
  logic            ready;
  logic            sel_load;
  logic            key_upd;
  logic [RC_W-1:0] round_cnt;
  logic [PH_W-1:0] phase;
  logic            last_round;
  logic            done;

`ifdef PRESENT_CTRL_ABORT_EN
  modport master (output start, output abort,
                  input ready, input sel_load, input key_upd, input round_cnt,
                  input phase, input last_round, input done);
  modport slave  (input start, input abort,
                  output ready, output sel_load, output key_upd, output round_cnt,
                  output phase, output last_round, output done);
`else
  modport master (output start,
                  input ready, input sel_load, input key_upd, input round_cnt,
                  input phase, input last_round, input done);
  modport slave  (input start,
                  output ready, output sel_load, output key_upd, output round_cnt,
                  output phase, output last_round, output done);
`endif

endinterface

// File: rtl/present_round_ctrl_phase_cnt.sv
// present_phase_cnt: modulo-SBOX_LAT phase counter pacing the shared S-box.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance the phase this edge
//   clr      : force the phase to 0 this edge (wins over en)
//   phase    : current phase, 0..SBOX_LAT-1
//   wrap     : high while en is set on the last phase (round completes)
module present_phase_cnt #(
  parameter int SBOX_LAT = 4,
  parameter int PH_W     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  output logic [PH_W-1:0] phase,
  output logic            wrap
);

  logic [PH_W-1:0] phase_reg, phase_next;
  logic            at_last;

  // With SBOX_LAT=1 the only phase is 0, so at_last is permanently true and
  // the counter never leaves 0 while wrap follows en every cycle.
  assign at_last = (phase_reg == PH_W'(SBOX_LAT - 1));
  assign wrap    = en && at_last;
  assign phase   = phase_reg;

  always_comb begin
    phase_next = phase_reg;
    if (clr) begin
      phase_next = '0;
    end else if (en) begin
      phase_next = at_last ? '0 : phase_reg + PH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_next;
    end
  end

endmodule

// File: rtl/present_round_ctrl.sv
// present_round_ctrl: round sequencer for the masked round-based PRESENT core.
// Drives the state/key load-vs-feedback select, paces the shared S-box,
// keeps the round counter feeding the key schedule and handshakes with the
// test wrapper.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : present_round_ctrl_if.slave (start/abort in, status out)
// Parameters: NUM_ROUNDS (full rounds), SBOX_LAT (cycles per round, >=1),
//             RC_W (round counter width).
// Optional feature macro: PRESENT_CTRL_ABORT_EN adds the abort input.
module present_round_ctrl import present_ctrl_pkg::*; #(
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
  parameter int SBOX_LAT   = DEF_SBOX_LAT,
  parameter int RC_W       = rc_w(NUM_ROUNDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  present_round_ctrl_if.slave  bus
);

  localparam int PH_W = ph_w(SBOX_LAT);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_ROUND = ST_ROUND;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]      state_reg, state_next;
  logic [RC_W-1:0] rc_reg, rc_next;
  logic [PH_W-1:0] phase;
  logic            in_round;
  logic            wrap;
  logic            phase_clr;
  logic            start_req;

`ifdef PRESENT_CTRL_ABORT_EN
  logic abort_req;
  // abort only matters while busy, and beats a coincident start in IDLE.
  assign abort_req = bus.abort && (state_reg != S_IDLE);
  assign start_req = bus.start && !bus.abort;
`else
  assign start_req = bus.start;
`endif

  assign in_round = (state_reg == S_ROUND);

  always_comb begin
    state_next = state_reg;
    rc_next    = rc_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_req) begin
          state_next = S_LOAD;
          rc_next    = RC_W'(1);
        end
      end
      S_LOAD: begin
        state_next = S_ROUND;
      end
      S_ROUND: begin
        if (wrap) begin
          if (rc_reg < RC_W'(NUM_ROUNDS)) begin
            rc_next = rc_reg + RC_W'(1);
          end else begin
            state_next = S_DONE;
            rc_next    = '0;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        rc_next    = '0;
      end
    endcase
`ifdef PRESENT_CTRL_ABORT_EN
    if (abort_req) begin
      state_next = S_IDLE;
      rc_next    = '0;
    end
`endif
  end

  // Clearing on anything but a stay in ROUND also covers an abort mid-round,
  // so phase is already 0 in the first IDLE cycle.
  assign phase_clr = (state_next != S_ROUND);

  present_phase_cnt #(
    .SBOX_LAT (SBOX_LAT),
    .PH_W     (PH_W)
  ) u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (in_round),
    .clr   (phase_clr),
    .phase (phase),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      rc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      rc_reg    <= rc_next;
    end
  end

  assign bus.ready      = (state_reg == S_IDLE);
  assign bus.sel_load   = (state_reg == S_LOAD);
  assign bus.key_upd    = wrap;
  assign bus.round_cnt  = rc_reg;
  assign bus.phase      = phase;
  assign bus.last_round = in_round && (rc_reg == RC_W'(NUM_ROUNDS));
`ifdef PRESENT_CTRL_ABORT_EN
  // The one deliberate path from an input: an abort landing on the DONE
  // cycle must still hide the completion from the wrapper.
  assign bus.done       = (state_reg == S_DONE) && !bus.abort;
`else
  assign bus.done       = (state_reg == S_DONE);
`endif

endmodule
